cp_remover: RTL and testbench



---
 rtl/cp_remover_pkg.sv | 12 +
 rtl/cp_remover_if.sv | 10 +
 rtl/cp_fifo.sv | 36 +++
 rtl/cp_remover.sv | 103 ++++++++++
 tb/tb_cp_remover.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/cp_remover_pkg.sv
// cp_remover_pkg: shared defaults, FSM states and ADC-to-IQ conversion for cp_remover
package cp_remover_pkg;
  localparam int N_FFT_DEF = 64;
  localparam int N_CP_DEF = 16;
  localparam int FIFO_DEPTH_DEF = 16;
  localparam int ADC_W = 14;
  localparam int IQ_W = 16;
  typedef enum logic [1:0] {S_CP = 2'd0, S_DATA = 2'd1, S_PAD = 2'd2} state_t;
  function automatic logic [31:0] to_iq(logic [ADC_W-1:0] d);
    return {16'h0000, {(IQ_W - ADC_W){d[ADC_W-1]}}, d};
  endfunction
endpackage

// File: rtl/cp_remover_if.sv
// cp_remover_if: AXI-stream bundle (tdata, tvalid, tready, tlast, tuser) with master/slave modports
interface cp_remover_if;
  logic [31:0] tdata;
  logic tvalid;
  logic tready;
  logic tlast;
  logic tuser;
  modport master(output tdata, tvalid, tlast, tuser, input tready);
  modport slave(input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/cp_fifo.sv
// cp_fifo: first-word-fall-through FIFO; ports clk, rst, push, pop, din -> dout, full, empty, ovf (push lost)
module cp_fifo #(
  parameter int W = 34,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic         ovf
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wr, rd;
  logic do_push, do_pop;
  assign empty = wr == rd;
  assign full = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign ovf = push && full && !do_pop;
  assign dout = empty ? '0 : mem[rd[AW-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (do_push) wr <= wr + 1'b1;
      if (do_pop) rd <= rd + 1'b1;
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr[AW-1:0]] <= din;
endmodule

// File: rtl/cp_remover.sv
// cp_remover: strips N_CP prefix samples per OFDM symbol, forwards N_FFT IQ samples (zero-padded on early frame end); ports aclk, areset, s_axis, m_axis, plus status_clr/ovf/err/sym_cnt when CP_REMOVER_STATUS_EN
module cp_remover
  import cp_remover_pkg::*;
#(
  parameter int N_FFT = N_FFT_DEF,
  parameter int N_CP = N_CP_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input logic aclk,
  input logic areset,
  cp_remover_if.slave s_axis,
  cp_remover_if.master m_axis
`ifdef CP_REMOVER_STATUS_EN
  ,
  input  logic        status_clr,
  output logic        status_ovf,
  output logic        status_err,
  output logic [15:0] status_sym_cnt
`endif
);
  localparam int CW = $clog2(N_FFT);
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [31:0] data;
  logic [33:0] din_q, dout;
  logic push, last, user, pad_err, push_q, full, empty, ovf, cp_end, fft_end, unused;
  assign cp_end = cnt == CW'(N_CP - 1);
  assign fft_end = cnt == CW'(N_FFT - 1);
  assign s_axis.tready = 1'b1;
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    push = 1'b0;
    last = 1'b0;
    user = 1'b0;
    pad_err = 1'b0;
    data = to_iq(s_axis.tdata[ADC_W-1:0]);
    case (state)
      S_CP: if (s_axis.tvalid) begin
        cnt_nxt = (s_axis.tlast || cp_end) ? '0 : cnt + 1'b1;
        state_nxt = (!s_axis.tlast && cp_end) ? S_DATA : S_CP;
      end
      S_DATA: if (s_axis.tvalid) begin
        push = 1'b1;
        last = fft_end;
        user = fft_end && s_axis.tlast;
        cnt_nxt = fft_end ? '0 : cnt + 1'b1;
        state_nxt = fft_end ? S_CP : (s_axis.tlast ? S_PAD : S_DATA);
      end
      default: begin
        push = 1'b1;
        data = '0;
        last = fft_end;
        user = fft_end;
        pad_err = s_axis.tvalid;
        cnt_nxt = fft_end ? '0 : cnt + 1'b1;
        state_nxt = fft_end ? S_CP : S_PAD;
      end
    endcase
  end
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      state <= S_CP;
      cnt <= '0;
      push_q <= 1'b0;
      din_q <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      push_q <= push;
      din_q <= {user, last, data};
    end
  cp_fifo #(.W(34), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(aclk),
    .rst(areset),
    .push(push_q),
    .pop(m_axis.tready),
    .din(din_q),
    .dout(dout),
    .full(full),
    .empty(empty),
    .ovf(ovf)
  );
  assign m_axis.tvalid = !empty;
  assign m_axis.tdata = dout[31:0];
  assign m_axis.tlast = dout[32];
  assign m_axis.tuser = dout[33];
`ifdef CP_REMOVER_STATUS_EN
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      status_ovf <= 1'b0;
      status_err <= 1'b0;
      status_sym_cnt <= '0;
    end else begin
      status_ovf <= !status_clr && (status_ovf || ovf);
      status_err <= !status_clr && (status_err || pad_err);
      status_sym_cnt <= status_sym_cnt + 16'(push && last);
    end
  assign unused = ^{s_axis.tdata[31:ADC_W], s_axis.tuser, full};
`else
  assign unused = ^{s_axis.tdata[31:ADC_W], s_axis.tuser, full, ovf, pad_err};
`endif
endmodule

// File: tb/tb_cp_remover.sv
// tb_cp_remover: self-checking bench for cp_remover against a frame-level reference model
module tb_cp_remover;
  localparam int CP = 16;
  localparam int SYM = 80;
  typedef struct packed {logic [31:0] d; logic l; logic u;} item_t;
  logic aclk = 1'b0;
  logic areset = 1'b1;
  logic rnd_rdy = 1'b0;
  int checks = 0;
  int passes = 0;
  int fails = 0;
  int gb = 0;
  item_t got_q[$];
  item_t exp_q[$];
  logic [31:0] v[$];
  cp_remover_if s_if();
  cp_remover_if m_if();
`ifdef CP_REMOVER_STATUS_EN
  logic status_clr = 1'b0;
  logic status_ovf, status_err;
  logic [15:0] status_sym_cnt;
  cp_remover dut (.aclk(aclk), .areset(areset), .s_axis(s_if.slave), .m_axis(m_if.master),
    .status_clr(status_clr), .status_ovf(status_ovf), .status_err(status_err), .status_sym_cnt(status_sym_cnt));
`else
  cp_remover dut (.aclk(aclk), .areset(areset), .s_axis(s_if.slave), .m_axis(m_if.master));
`endif
  always #5 aclk = ~aclk;
  always @(negedge aclk)
    if (m_if.tvalid && m_if.tready) got_q.push_back('{m_if.tdata, m_if.tlast, m_if.tuser});
  function automatic logic [31:0] conv(input logic [31:0] x);
    int s = int'(x % 32'd16384);
    if (s >= 8192) s -= 16384;
    return 32'(s) & 32'h0000_FFFF;
  endfunction
  task automatic model_frame(input logic [31:0] f[$]);
    int off;
    for (int p = 0; p < f.size(); p++) begin
      off = p % SYM;
      if (off >= CP) exp_q.push_back('{conv(f[p]), off == SYM - 1, off == SYM - 1 && p == f.size() - 1});
    end
    off = (f.size() - 1) % SYM;
    if (off >= CP && off != SYM - 1)
      for (int k = off + 1; k < SYM; k++) exp_q.push_back('{32'h0, k == SYM - 1, k == SYM - 1});
  endtask
  task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
      if (rnd_rdy) m_if.tready = $urandom_range(7) != 0;
    end
  endtask
  task automatic drive(input logic [31:0] d, input logic l);
    s_if.tdata = d;
    s_if.tlast = l;
    s_if.tvalid = 1'b1;
    idle(1);
    s_if.tvalid = 1'b0;
    s_if.tlast = 1'b0;
  endtask
  task automatic send_frame(input logic [31:0] f[$], input int gap_pct);
    foreach (f[i]) begin
      if (int'($urandom_range(99)) < gap_pct) idle($urandom_range(1, 2));
      drive(f[i], i == f.size() - 1);
    end
  endtask
  task automatic idx_frame(input int n);
    v.delete();
    for (int i = 0; i < n; i++) v.push_back(32'(i));
  endtask
  task automatic check_out(input string tag);
    int n = 0;
    while (got_q.size() - gb < exp_q.size() && n < 3000) begin
      idle(1);
      n++;
    end
    idle(8);
    check({tag, "_count"}, 34'(got_q.size() - gb), 34'(exp_q.size()));
    foreach (exp_q[i])
      if (gb + i < got_q.size()) check($sformatf("%s_item%0d", tag, i), got_q[gb + i], exp_q[i]);
    gb = got_q.size();
    exp_q.delete();
  endtask
`ifdef CP_REMOVER_STATUS_EN
  task automatic clr();
    status_clr = 1'b1;
    idle(1);
    status_clr = 1'b0;
    idle(1);
  endtask
`endif
  initial begin
    int g0;
    s_if.tdata = '0;
    s_if.tvalid = 1'b0;
    s_if.tlast = 1'b0;
    s_if.tuser = 1'b0;
    m_if.tready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    areset = 1'b0;
    check("rst_tvalid", 34'(m_if.tvalid), 34'(0));
    check("rst_tdata", 34'(m_if.tdata), 34'(0));
    check("rst_tlast", 34'(m_if.tlast), 34'(0));
    check("rst_tuser", 34'(m_if.tuser), 34'(0));
    check("tready_const", 34'(s_if.tready), 34'(1));
    idx_frame(160);
    model_frame(v);
    send_frame(v, 0);
    check_out("frame160");
`ifdef CP_REMOVER_STATUS_EN
    check("sym_cnt", 34'(status_sym_cnt), 34'(2));
`endif
    idx_frame(SYM);
    v[20] = 32'hABCD_2000;
    v[21] = 32'h0000_1FFF;
    model_frame(v);
    g0 = gb;
    for (int i = 0; i < SYM; i++) begin
      drive(v[i], i == SYM - 1);
      if (i == CP) begin
        check("lat_t1", 34'(m_if.tvalid), 34'(0));
        idle(1);
        check("lat_t2", 34'(m_if.tvalid), 34'(1));
        check("lat_data", 34'(m_if.tdata), 34'(32'h10));
      end
    end
    check_out("conv");
    if (got_q.size() > g0 + 5) begin
      check("neg_fullscale", 34'(got_q[g0 + 4].d), 34'(32'h0000_E000));
      check("pos_fullscale", 34'(got_q[g0 + 5].d), 34'(32'h0000_1FFF));
    end
`ifdef CP_REMOVER_STATUS_EN
    check("err_clear", 34'(status_err), 34'(0));
`endif
    idx_frame(50);
    model_frame(v);
    send_frame(v, 0);
    drive(32'd999, 1'b0);
    check_out("pad");
`ifdef CP_REMOVER_STATUS_EN
    check("err_set", 34'(status_err), 34'(1));
    clr();
    check("err_clr", 34'(status_err), 34'(0));
`endif
    m_if.tready = 1'b0;
    idx_frame(SYM);
    model_frame(v);
    while (exp_q.size() > 16) void'(exp_q.pop_back());
    send_frame(v, 0);
    idle(5);
`ifdef CP_REMOVER_STATUS_EN
    check("ovf_set", 34'(status_ovf), 34'(1));
`endif
    m_if.tready = 1'b1;
    check_out("ovf");
`ifdef CP_REMOVER_STATUS_EN
    clr();
    check("ovf_clr", 34'(status_ovf), 34'(0));
`endif
    idx_frame(10);
    model_frame(v);
    send_frame(v, 0);
    idx_frame(SYM);
    model_frame(v);
    send_frame(v, 20);
    check_out("cp_tlast");
    idx_frame(31);
    foreach (v[i]) drive(v[i], 1'b0);
    areset = 1'b1;
    @(negedge aclk);
    check("areset_tvalid", 34'(m_if.tvalid), 34'(0));
    check("areset_tdata", 34'(m_if.tdata), 34'(0));
    idle(2);
    areset = 1'b0;
    gb = got_q.size();
`ifdef CP_REMOVER_STATUS_EN
    check("areset_sym_cnt", 34'(status_sym_cnt), 34'(0));
`endif
    idx_frame(160);
    model_frame(v);
    send_frame(v, 0);
    check_out("post_reset");
`ifdef CP_REMOVER_STATUS_EN
    check("post_reset_sym_cnt", 34'(status_sym_cnt), 34'(2));
`endif
    rnd_rdy = 1'b1;
    for (int f = 0; f < 3; f++) begin
      int len = int'($urandom_range(1, 3)) * SYM + ($urandom_range(1) == 0 ? 0 : int'($urandom_range(1, 16)));
      v.delete();
      for (int i = 0; i < len; i++) v.push_back($urandom);
      model_frame(v);
      send_frame(v, 30);
    end
    check_out("random");
    rnd_rdy = 1'b0;
    m_if.tready = 1'b1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
